// File: rtl/rolling_variance_engine.sv
// rolling_variance_engine
// Per-stock rolling mean and exact integer variance of the quote mid-price over
// a WINDOW-deep circular buffer. Three-stage pipeline: buffer read/write, running
// sum update, variance evaluation. Results appear three cycles after each quote.
module rolling_variance_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 16,
  parameter int NUM_STOCKS = 4,
  localparam int LW = $clog2(WINDOW),
  localparam int SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [SW-1:0]           i_stock_id,
  input  logic [DATA_WIDTH-1:0]   i_best_ask,
  input  logic [DATA_WIDTH-1:0]   i_best_bid,
  input  logic                    i_clear,
  input  logic [SW-1:0]           i_clear_id,
  output logic                    o_valid,
  output logic [SW-1:0]           o_stock_id,
  output logic [DATA_WIDTH-1:0]   o_mean,
  output logic [2*DATA_WIDTH-1:0] o_variance,
  output logic                    o_warm
);

  localparam int DW    = DATA_WIDTH;
  localparam int SUMW  = DW + LW;
  localparam int SQW   = 2 * DW + LW;
  localparam int VW    = 2 * DW + 2 * LW;
  localparam int DEPTH = NUM_STOCKS * WINDOW;
  localparam logic [LW:0] FILL_FULL = (LW + 1)'(WINDOW);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [DW-1:0]   r_rd_data;

  logic [LW-1:0]   r_ptr   [NUM_STOCKS];
  logic [LW:0]     r_fill  [NUM_STOCKS];
  logic [SUMW-1:0] r_sum   [NUM_STOCKS];
  logic [SQW-1:0]  r_sumsq [NUM_STOCKS];

  logic            r_s1_valid;
  logic [SW-1:0]   r_s1_stock;
  logic [DW-1:0]   r_s1_mid;
  logic            r_s1_was_full;
  logic            r_s1_warm;

  logic            r_s2_valid;
  logic [SW-1:0]   r_s2_stock;
  logic [SUMW-1:0] r_s2_sum;
  logic [SQW-1:0]  r_s2_sumsq;
  logic            r_s2_warm;

  // Stage 0: mid-price, effective pointer/fill (a same-stock clear restarts the window)
  logic [DW:0]       w_mid_sum;
  logic [DW-1:0]     w_mid;
  logic              w_clr_hit;
  logic [LW-1:0]     w_ptr_cur;
  logic [LW-1:0]     w_ptr_nxt;
  logic [LW:0]       w_fill_cur;
  logic [LW:0]       w_fill_nxt;
  logic              w_was_full;
  logic [SW+LW-1:0]  w_addr;

  assign w_mid_sum  = {1'b0, i_best_ask} + {1'b0, i_best_bid};
  assign w_mid      = DW'(w_mid_sum >> 1);
  assign w_clr_hit  = i_clear && (i_clear_id == i_stock_id);
  assign w_ptr_cur  = w_clr_hit ? '0 : r_ptr[i_stock_id];
  assign w_fill_cur = w_clr_hit ? '0 : r_fill[i_stock_id];
  assign w_was_full = (w_fill_cur == FILL_FULL);
  assign w_fill_nxt = w_was_full ? FILL_FULL : w_fill_cur + 1'b1;
  assign w_ptr_nxt  = w_ptr_cur + 1'b1;
  assign w_addr     = {i_stock_id, w_ptr_cur};

  // Stage 1: remove the evicted sample (only once the window is full) and add the new one
  logic [DW-1:0]   w_old;
  logic [2*DW-1:0] w_mid_sq;
  logic [2*DW-1:0] w_old_sq;
  logic [SUMW-1:0] w_sum_nxt;
  logic [SQW-1:0]  w_sumsq_nxt;

  assign w_old       = r_s1_was_full ? r_rd_data : '0;
  assign w_mid_sq    = {{DW{1'b0}}, r_s1_mid} * {{DW{1'b0}}, r_s1_mid};
  assign w_old_sq    = {{DW{1'b0}}, w_old} * {{DW{1'b0}}, w_old};
  assign w_sum_nxt   = r_sum[r_s1_stock] + SUMW'(r_s1_mid) - SUMW'(w_old);
  assign w_sumsq_nxt = r_sumsq[r_s1_stock] + SQW'(w_mid_sq) - SQW'(w_old_sq);

  // Stage 2: WINDOW*sumsq - sum^2, never negative
  logic [VW-1:0] w_sum_ext;
  logic [VW-1:0] w_sum_sq;
  logic [VW-1:0] w_sumsq_sh;
  logic [VW-1:0] w_var_full;

  assign w_sum_ext  = VW'(r_s2_sum);
  assign w_sum_sq   = w_sum_ext * w_sum_ext;
  assign w_sumsq_sh = {r_s2_sumsq, {LW{1'b0}}};
  assign w_var_full = w_sumsq_sh - w_sum_sq;

  // Sample buffer: read-before-write, contents deliberately not reset
  always_ff @(posedge i_clk) begin
    if (i_valid && !i_reset) begin
      r_mem[w_addr] <= w_mid;
    end
    r_rd_data <= r_mem[w_addr];
  end

  // Per-stock pointer, fill and running sums; a clear overrides a same-edge sum update
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        r_ptr[s]   <= '0;
        r_fill[s]  <= '0;
        r_sum[s]   <= '0;
        r_sumsq[s] <= '0;
      end
    end else begin
      if (r_s1_valid) begin
        r_sum[r_s1_stock]   <= w_sum_nxt;
        r_sumsq[r_s1_stock] <= w_sumsq_nxt;
      end
      if (i_valid) begin
        r_ptr[i_stock_id]  <= w_ptr_nxt;
        r_fill[i_stock_id] <= w_fill_nxt;
      end
      if (i_clear) begin
        r_sum[i_clear_id]   <= '0;
        r_sumsq[i_clear_id] <= '0;
        if (!(i_valid && (i_stock_id == i_clear_id))) begin
          r_ptr[i_clear_id]  <= '0;
          r_fill[i_clear_id] <= '0;
        end
      end
    end
  end

  // Pipeline registers and output stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_stock    <= '0;
      r_s1_mid      <= '0;
      r_s1_was_full <= 1'b0;
      r_s1_warm     <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_s2_stock    <= '0;
      r_s2_sum      <= '0;
      r_s2_sumsq    <= '0;
      r_s2_warm     <= 1'b0;
      o_valid       <= 1'b0;
      o_stock_id    <= '0;
      o_mean        <= '0;
      o_variance    <= '0;
      o_warm        <= 1'b0;
    end else begin
      r_s1_valid    <= i_valid;
      r_s1_stock    <= i_stock_id;
      r_s1_mid      <= w_mid;
      r_s1_was_full <= w_was_full;
      r_s1_warm     <= (w_fill_nxt == FILL_FULL);

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_stock <= r_s1_stock;
        r_s2_sum   <= w_sum_nxt;
        r_s2_sumsq <= w_sumsq_nxt;
        r_s2_warm  <= r_s1_warm;
      end

      o_valid <= r_s2_valid;
      if (r_s2_valid) begin
        o_stock_id <= r_s2_stock;
        o_mean     <= DW'(r_s2_sum >> LW);
        o_variance <= (2 * DW)'(w_var_full >> (2 * LW));
        o_warm     <= r_s2_warm;
      end
    end
  end

endmodule

// File: tb/tb_rolling_variance_engine.sv
// Bench for rolling_variance_engine: WINDOW=4, NUM_STOCKS=4, DATA_WIDTH=32.
// Expected results come from a per-stock history queue evaluated with plain
// arithmetic; a monitor compares every DUT result against the scoreboard.
module tb_rolling_variance_engine;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int NS = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [SW-1:0]   sid;
  logic [DW-1:0]   ask;
  logic [DW-1:0]   bid;
  logic            clear;
  logic [SW-1:0]   cid;
  logic            o_valid;
  logic [SW-1:0]   o_stock_id;
  logic [DW-1:0]   o_mean;
  logic [2*DW-1:0] o_variance;
  logic            o_warm;

  rolling_variance_engine #(.DATA_WIDTH(DW), .WINDOW(W), .NUM_STOCKS(NS)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_stock_id(sid),
    .i_best_ask(ask), .i_best_bid(bid), .i_clear(clear), .i_clear_id(cid),
    .o_valid(o_valid), .o_stock_id(o_stock_id), .o_mean(o_mean),
    .o_variance(o_variance), .o_warm(o_warm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int              cyc;
    logic [SW-1:0]   sid;
    logic [DW-1:0]   mean;
    logic [2*DW-1:0] vr;
    logic            warm;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  logic [DW-1:0] hist[NS][$];
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: window = last W mids of the stock, zero padded when short
  task automatic model_quote(input int s, input logic [DW-1:0] pa, input logic [DW-1:0] pb);
    logic [DW:0]    tsum;
    logic [DW-1:0]  mid;
    logic [127:0]   sm;
    logic [127:0]   sq;
    logic [127:0]   x;
    exp_t           e;
    tsum = {1'b0, pa} + {1'b0, pb};
    mid  = tsum[DW:1];
    hist[s].push_back(mid);
    if (hist[s].size() > W) hist[s].delete(0);
    sm = 0;
    sq = 0;
    for (int i = 0; i < hist[s].size(); i++) begin
      x  = 128'(hist[s][i]);
      sm = sm + x;
      sq = sq + x * x;
    end
    e.cyc  = cyc + 3;
    e.sid  = SW'(s);
    e.mean = DW'(sm / W);
    e.vr   = (2*DW)'((128'(W) * sq - sm * sm) / (W * W));
    e.warm = (hist[s].size() == W);
    sbq.push_back(e);
  endtask

  // One input cycle; a clear takes effect before a same-edge quote
  task automatic cycle(input bit v, input int s, input logic [DW-1:0] pa, input logic [DW-1:0] pb,
                       input bit c = 1'b0, input int cs = 0);
    @(negedge clk);
    valid = v;
    sid   = SW'(s);
    ask   = pa;
    bid   = pb;
    clear = c;
    cid   = SW'(cs);
    if (c) hist[cs].delete();
    if (v) model_quote(s, pa, pb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, '0);
  endtask

  // Reset for n edges; results not yet emitted are discarded, as are all windows
  task automatic do_reset(input int n);
    exp_t keep[$];
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    clear = 1'b1;
    cid   = '0;
    for (int s = 0; s < NS; s++) hist[s].delete();
    keep.delete();
    for (int i = 0; i < sbq.size(); i++) if (sbq[i].cyc <= cyc) keep.push_back(sbq[i]);
    sbq = keep;
    repeat (n) @(negedge clk);
    rst   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 128'(o_valid), 128'(0));
    chk({tag, "_stock"}, 128'(o_stock_id), 128'(0));
    chk({tag, "_mean"}, 128'(o_mean), 128'(0));
    chk({tag, "_var"}, 128'(o_variance), 128'(0));
    chk({tag, "_warm"}, 128'(o_warm), 128'(0));
  endtask

  function automatic logic [DW-1:0] rnd_price();
    logic [DW-1:0] r;
    case ($urandom_range(3))
      0:       r = DW'($urandom_range(15));
      1:       r = ($urandom_range(1) == 1) ? '1 : '0;
      default: r = DW'($urandom());
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (o_valid !== 1'b0) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got o_valid=%b stock=%0d expected no result (cycle %0d)",
                 o_valid, o_stock_id, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("latency", 128'(cyc), 128'(mon_e.cyc));
        chk("stock_id", 128'(o_stock_id), 128'(mon_e.sid));
        chk("mean", 128'(o_mean), 128'(mon_e.mean));
        chk("variance", 128'(o_variance), 128'(mon_e.vr));
        chk("warm", 128'(o_warm), 128'(mon_e.warm));
      end
    end
  end

  int            seq[5];
  bit            rv;
  bit            rc;
  int            rs;
  int            rcs;
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    clear = 1'b0;
    sid   = '0;
    cid   = '0;
    ask   = '0;
    bid   = '0;
    seq   = '{1, 3, 1, 3, 5};

    do_reset(3);
    chk_idle_outputs("reset");

    // Constant mid 10 on stock 0
    for (int i = 0; i < 4; i++) cycle(1'b1, 0, 32'd11, 32'd9);
    // Stock 1: 1,3,1,3 then 5
    for (int k = 0; k < 5; k++) cycle(1'b1, 1, DW'(seq[k]), DW'(seq[k]));
    idle(5);
    do_reset(1);

    // Interleaved stocks, each with the same mid sequence
    for (int k = 0; k < 5; k++)
      for (int s = 0; s < NS; s++) cycle(1'b1, s, DW'(seq[k]), DW'(seq[k]));
    idle(5);
    do_reset(1);

    // Warm stock 2, then clear + quote on it at the same edge
    for (int i = 0; i < 4; i++) cycle(1'b1, 2, 32'd4, 32'd4);
    cycle(1'b1, 2, 32'd8, 32'd8, 1'b1, 2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 2, 32'd8, 32'd8);
    // Clear one edge after a quote drops it; clear of another stock alongside a quote
    cycle(1'b1, 0, 32'd6, 32'd6);
    cycle(1'b1, 0, 32'd7, 32'd7);
    cycle(1'b1, 1, 32'd9, 32'd9, 1'b1, 0);
    cycle(1'b1, 0, 32'd2, 32'd2, 1'b1, 3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, 32'd2, 32'd4);
    idle(5);

    // Reset one cycle after a quote: the in-flight result never appears
    cycle(1'b1, 3, 32'd100, 32'd50);
    do_reset(1);
    chk_idle_outputs("midreset");
    idle(4);
    for (int i = 0; i < 4; i++) cycle(1'b1, 3, 32'd20, 32'd30);
    cycle(1'b1, 2, 32'd1, 32'd1);

    // Full-scale alternating mids
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cycle(1'b1, 1, '1, '1);
      else            cycle(1'b1, 1, '0, '0);
    end

    // Random traffic with occasional clears
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(3) != 0);
      rs  = int'($urandom_range(NS - 1));
      rc  = ($urandom_range(15) == 0);
      rcs = int'($urandom_range(NS - 1));
      ra  = rnd_price();
      rb  = rnd_price();
      cycle(rv, rs, ra, rb, rc, rcs);
    end
    idle(8);
    chk("drain", 128'(sbq.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rolling_variance_engine.md
# rolling_variance_engine

Per-stock rolling mean and variance of mid-price over a fixed window, for the spread and reference-price path. Computes mid = (ask+bid)/2 for each valid quote, keeps a per-stock circular window of the last WINDOW mids with internally generated write pointers, and maintains running sum and sum-of-squares. It emits mean and exact integer variance three cycles after each sample, with a per-stock warm flag and a single-cycle per-stock clear.

## Interface
- DATA_WIDTH, 32, price width (unsigned)
- WINDOW, 16, samples per window; power of two, ≥2; LW = log2(WINDOW)
- NUM_STOCKS, 4, independent channels; SW = max(1, $clog2(NUM_STOCKS))

One clock; reset is synchronous and active-high.

- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous active-high reset
- i_valid  in  1  quote present this cycle
- i_stock_id  in  SW  channel of quote
- i_best_ask  in  DATA_WIDTH  best ask
- i_best_bid  in  DATA_WIDTH  best bid
- i_clear  in  1  flush one channel's window
- i_clear_id  in  SW  channel to flush
- o_valid  out  1  result strobe, one cycle per accepted quote
- o_stock_id  out  SW  channel of result
- o_mean  out  DATA_WIDTH  sum >> LW
- o_variance  out  2*DATA_WIDTH  (WINDOW*sumsq − sum²) >> 2*LW
- o_warm  out  1  window for o_stock_id held WINDOW real samples when result computed

## Operation
- Mid = (ask + bid) >> 1, computed at DATA_WIDTH+1 bits and truncated to DATA_WIDTH; no overflow possible.
- Storage: NUM_STOCKS*WINDOW × DATA_WIDTH, address {stock, ptr[stock]}. Registered read-before-write: the same-cycle read returns the old content.
- Per-stock state: ptr (LW bits, wraps WINDOW−1→0), fill (0..WINDOW, saturates at WINDOW), sum (DATA_WIDTH+LW bits), sumsq (2*DATA_WIDTH+LW bits). All unsigned; no overflow by construction.
- Stage 0, input cycle, i_valid: write mid at the address, read old value, ptr++, fill = min(fill+1, WINDOW). Register stock, mid, and was_full = (fill==WINDOW before increment).
- Stage 1: old = was_full ? read data : 0, so stale buffer content is never used. Compute sum += mid − old and sumsq += mid² − old². Single-cycle read-modify-write, so back-to-back samples on one stock need no forwarding. Register the new sum, sumsq, stock, and warm = (fill after stage 0 == WINDOW).
- Stage 2: variance = (sumsq << LW) − sum², result >> 2*LW. Always ≥0 (Cauchy–Schwarz). Mean = sum >> LW. Register to outputs.
- When o_warm=0, the outputs are computed over WINDOW with zero padding. Downstream ignores them.
- Clear: at the sampling edge, ptr, fill, sum and sumsq of i_clear_id go to 0. Buffer contents are not touched; the fill gating makes them invisible.
- Clear vs. stage-1 update of the same stock at the same edge: clear wins and that sample's contribution is dropped. Its result is still emitted with its computed values.
- Clear and i_valid on the same stock at the same edge: the quote becomes sample 0 of the new window (ptr=1, fill=1, was_full=0).
- Clear on a different stock has no interaction.
- No backpressure. One quote accepted every cycle.

## Timing
- Quote presented in cycle C produces o_valid in cycle C+3 with the matching o_stock_id. Throughput is 1/cycle, in order.
- o_valid is high for exactly one cycle per accepted quote. It is never asserted without a quote.
- Reset: o_valid=0, o_stock_id=0, o_mean=0, o_variance=0, o_warm=0. All ptr/fill/sum/sumsq are 0 and pipeline valids are cleared. The buffer is not reset.
- Reset mid-operation: in-flight results (≤3) are discarded and never appear on o_valid. The first post-reset quote restarts every stock from empty.
- i_clear and i_clear_id are ignored during reset.

## Test plan
Run with WINDOW=4, NUM_STOCKS=4, DATA_WIDTH=32 unless noted.
- Stock 0, (ask,bid)=(11,9)×4 back-to-back → mids 10; four o_valid at C+3…C+6; o_mean 10 on the 4th; o_variance 0; o_warm 0,0,0,1.
- Stock 1, mids 1,3,1,3 then 5 → 4th result mean 2, variance 1, warm 1; 5th (window 3,1,3,5) mean 3, variance 2.
- Interleave stocks 0/1/2/3 every cycle, each with the mid sequence of the previous scenario → each stock's results match its isolated run; o_stock_id ordering equals input ordering.
- Warm stock 2 (mids 4,4,4,4), then i_clear on stock 2 with i_valid mid 8 for stock 2 at the same edge → that result has mean 2 (8>>2), warm 0. Three more mids 8 → warm 1, variance 0.
- Assert i_reset for 1 cycle one cycle after a quote → no o_valid for the in-flight quote; outputs 0. A fresh 4-sample run on that stock gives warm only on the 4th.
- DATA_WIDTH=32, ask=bid=0xFFFFFFFF, alternating with 0 → mid 0xFFFFFFFF/0; variance (2^32−1)²/4 exact at full width with no wrap.
